// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generator, fixed-latency imem request pipe, DEPTH-entry return FIFO.
// Latency: first out_valid MEM_LATENCY+1 cycles after the first imem_req; one instruction per cycle sustained.
// Backpressure: stall holds the FIFO head; requests are credit-limited so a return always finds a free slot.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr    fetch request and its address (pc)
//   imem_instr            instruction returned MEM_LATENCY cycles after its request
//   stall                 decoder cannot accept the head this cycle
//   redirect/_addr        flush all buffered and in-flight fetches, restart at redirect_addr
//   out_valid/_instr/_addr FIFO head towards the decoder (zero when empty)
//   occupancy             number of FIFO entries
module fetch_queue #(
   parameter int              XLEN        = 32,
   parameter int              DEPTH       = 4,
   parameter int              MEM_LATENCY = 2,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [31:0]                imem_instr,
   input  logic                       stall,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_addr,
   output logic                       out_valid,
   output logic [31:0]                out_instr,
   output logic [XLEN-1:0]            out_addr,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);
   // one extra bit so occupancy + inflight cannot overflow before the compare
   localparam int CW = OW + 1;

   logic [XLEN-1:0]        pc;
   logic [MEM_LATENCY-1:0] dl_vld;
   logic [XLEN-1:0]        dl_addr [MEM_LATENCY];
   logic [31:0]            fifo_instr [DEPTH];
   logic [XLEN-1:0]        fifo_addr [DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [OW-1:0]          count;
   logic [CW-1:0]          inflight;
   logic [CW-1:0]          credit_need;
   logic                   deq;
   logic                   enq;
   logic                   ret_vld;
   logic [XLEN-1:0]        ret_addr;

   // the last delay-line slot lines up with the instruction on imem_instr
   assign ret_vld  = dl_vld[MEM_LATENCY-1];
   assign ret_addr = dl_addr[MEM_LATENCY-1];

   assign out_valid = (count != '0);
   assign deq       = out_valid & ~stall & ~redirect;
   // a return in the redirect cycle belongs to the old stream and is dropped
   assign enq       = ret_vld & ~redirect;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight = inflight + CW'(dl_vld[i]);
      end
   end

   // Every in-flight fetch already owns a FIFO slot; a slot freed by this
   // cycle's dequeue may be reused immediately.
   assign credit_need = CW'(count) + inflight - CW'(deq);
   // reset gates the request so it drops as soon as reset asserts
   assign imem_req    = reset & ~redirect & (credit_need < CW'(DEPTH));
   assign imem_addr   = pc;

   assign occupancy = count;
   assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
   assign out_addr  = out_valid ? fifo_addr[rd_ptr]  : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_addr;
      end else if (imem_req) begin
         pc <= pc + XLEN'(4);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dl_vld <= '0;
      end else if (redirect) begin
         dl_vld <= '0;
      end else begin
         dl_vld[0] <= imem_req;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            dl_vld[i] <= dl_vld[i-1];
         end
      end
   end

   // addresses are qualified by dl_vld and need no reset
   always_ff @(posedge clock) begin
      dl_addr[0] <= pc;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         dl_addr[i] <= dl_addr[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         count <= count + OW'(enq) - OW'(deq);
      end
   end

   always_ff @(posedge clock) begin
      if (enq) begin
         fifo_instr[wr_ptr] <= imem_instr;
         fifo_addr[wr_ptr]  <= ret_addr;
      end
   end

   // the credit rule makes a return into a full, non-draining FIFO impossible
   a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
      !(enq && !deq && count == OW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model and memory responder.
// Latency: model predicts every output each cycle; literal checks pin key cycles.
// Backpressure: stall/redirect driven from the stimulus sequence.
module tb_fetch_queue;

   localparam int XLEN = 32;
   localparam int DEPTH = 4;
   localparam int ML = 2;
   localparam int TRN = 128;

   logic              clock;
   logic              reset;
   logic              imem_req;
   logic [XLEN-1:0]   imem_addr;
   logic [31:0]       imem_instr;
   logic              stall;
   logic              redirect;
   logic [XLEN-1:0]   redirect_addr;
   logic              out_valid;
   logic [31:0]       out_instr;
   logic [XLEN-1:0]   out_addr;
   logic [2:0]        occupancy;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MEM_LATENCY(ML), .RESET_PC('0)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
      .out_valid(out_valid), .out_instr(out_instr), .out_addr(out_addr),
      .occupancy(occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model: buffered entries, outstanding fetches, next pc
   logic [31:0] fq_addr [$];
   logic [31:0] fq_instr [$];
   logic [31:0] infl_addr [$];
   int          infl_due [$];
   logic [31:0] m_pc;
   // memory responder: answers every request it sees, stale or not
   logic [31:0] mem_addr [$];
   int          mem_due [$];

   // per-cycle DUT samples for the literal checks
   logic        tr_req [TRN];
   logic [31:0] tr_iaddr [TRN];
   logic        tr_vld [TRN];
   logic [31:0] tr_oaddr [TRN];
   logic [31:0] tr_oinstr [TRN];
   logic [31:0] tr_occ [TRN];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      fq_addr.delete();
      fq_instr.delete();
      infl_addr.delete();
      infl_due.delete();
   endtask

   // one clock cycle: drive memory, compare, advance model; enters and leaves at negedge
   task automatic step();
      logic       exp_v;
      logic       dq;
      logic       ereq;
      int         eo;
      if (mem_due.size() > 0 && mem_due[0] == cyc) begin
         imem_instr = mem_addr[0] ^ 32'hFFFF0000;
         void'(mem_due.pop_front());
         void'(mem_addr.pop_front());
      end else begin
         imem_instr = 32'hBAD00000 ^ 32'(cyc);
      end
      #1;
      eo    = fq_addr.size();
      exp_v = (eo > 0);
      dq    = exp_v && !stall && !redirect;
      ereq  = !redirect && ((eo + infl_addr.size() - int'(dq)) < DEPTH);
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      chk("occupancy", {29'b0, occupancy}, 32'(eo));
      chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
      if (exp_v) begin
         chk("out_addr", out_addr, fq_addr[0]);
         chk("out_instr", out_instr, fq_instr[0]);
      end
      if (ereq) chk("imem_addr", imem_addr, m_pc);
      if (cyc < TRN) begin
         tr_req[cyc]    = imem_req;
         tr_iaddr[cyc]  = imem_addr;
         tr_vld[cyc]    = out_valid;
         tr_oaddr[cyc]  = out_addr;
         tr_oinstr[cyc] = out_instr;
         tr_occ[cyc]    = {29'b0, occupancy};
      end
      if (imem_req) begin
         mem_due.push_back(cyc + ML);
         mem_addr.push_back(imem_addr);
      end
      if (redirect) begin
         model_clear();
         m_pc = redirect_addr;
      end else begin
         if (dq) begin
            void'(fq_addr.pop_front());
            void'(fq_instr.pop_front());
         end
         if (infl_due.size() > 0 && infl_due[0] == cyc) begin
            fq_addr.push_back(infl_addr[0]);
            fq_instr.push_back(imem_instr);
            void'(infl_addr.pop_front());
            void'(infl_due.pop_front());
         end
         if (ereq) begin
            infl_addr.push_back(m_pc);
            infl_due.push_back(cyc + ML);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
      chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_occupancy"}, {29'b0, occupancy}, 32'd0);
      chk({tag, "_out_addr"}, out_addr, 32'd0);
      chk({tag, "_out_instr"}, out_instr, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_addr = '0;
      imem_instr = '0;
      m_pc = 32'd0;
      #1;
      chk_reset_outputs("reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      // startup, cycles 0..7
      run(8);
      chk("lit_req0", {31'b0, tr_req[0]}, 32'd1);
      chk("lit_iaddr0", tr_iaddr[0], 32'h0);
      chk("lit_iaddr1", tr_iaddr[1], 32'h4);
      chk("lit_iaddr2", tr_iaddr[2], 32'h8);
      chk("lit_vld2", {31'b0, tr_vld[2]}, 32'd0);
      chk("lit_vld3", {31'b0, tr_vld[3]}, 32'd1);
      chk("lit_oaddr3", tr_oaddr[3], 32'h0);
      chk("lit_oinstr3", tr_oinstr[3], 32'hFFFF0000);
      chk("lit_oaddr4", tr_oaddr[4], 32'h4);
      chk("lit_oaddr5", tr_oaddr[5], 32'h8);
      chk("lit_occ5", tr_occ[5], 32'd1);

      // stall fill, cycles 8..12, then drain 13..24
      stall = 1'b1;
      run(5);
      chk("lit_req8", {31'b0, tr_req[8]}, 32'd1);
      chk("lit_req9", {31'b0, tr_req[9]}, 32'd0);
      chk("lit_occ11", tr_occ[11], 32'd4);
      chk("lit_oaddr12", tr_oaddr[12], 32'h14);
      stall = 1'b0;
      run(12);
      chk("lit_oaddr13", tr_oaddr[13], 32'h14);
      chk("lit_oaddr14", tr_oaddr[14], 32'h18);
      chk("lit_oaddr15", tr_oaddr[15], 32'h1C);
      chk("lit_oaddr16", tr_oaddr[16], 32'h20);
      chk("lit_oaddr17", tr_oaddr[17], 32'h24);

      // redirect with fetches in flight, cycle 25
      redirect = 1'b1;
      redirect_addr = 32'h100;
      step();
      redirect = 1'b0;
      run(9);
      chk("lit_req25", {31'b0, tr_req[25]}, 32'd0);
      chk("lit_occ26", tr_occ[26], 32'd0);
      chk("lit_vld26", {31'b0, tr_vld[26]}, 32'd0);
      chk("lit_req26", {31'b0, tr_req[26]}, 32'd1);
      chk("lit_iaddr26", tr_iaddr[26], 32'h100);
      chk("lit_vld28", {31'b0, tr_vld[28]}, 32'd0);
      chk("lit_oaddr29", tr_oaddr[29], 32'h100);
      chk("lit_oaddr30", tr_oaddr[30], 32'h104);

      // redirect while stalled on a full FIFO, cycle 41
      stall = 1'b1;
      run(6);
      chk("lit_occ40", tr_occ[40], 32'd4);
      chk("lit_req40", {31'b0, tr_req[40]}, 32'd0);
      redirect = 1'b1;
      redirect_addr = 32'h200;
      step();
      redirect = 1'b0;
      stall = 1'b0;
      run(8);
      chk("lit_occ42", tr_occ[42], 32'd0);
      chk("lit_iaddr42", tr_iaddr[42], 32'h200);
      chk("lit_oaddr45", tr_oaddr[45], 32'h200);

      // address wrap, redirect at cycle 50
      redirect = 1'b1;
      redirect_addr = 32'hFFFFFFFC;
      step();
      redirect = 1'b0;
      run(9);
      chk("lit_iaddr51", tr_iaddr[51], 32'hFFFFFFFC);
      chk("lit_iaddr52", tr_iaddr[52], 32'h0);
      chk("lit_oaddr54", tr_oaddr[54], 32'hFFFFFFFC);
      chk("lit_oinstr54", tr_oinstr[54], 32'h0000FFFC);
      chk("lit_oaddr55", tr_oaddr[55], 32'h0);
      chk("lit_oaddr56", tr_oaddr[56], 32'h4);

      // back-to-back redirects at cycles 60, 61
      redirect = 1'b1;
      redirect_addr = 32'h300;
      step();
      redirect_addr = 32'h400;
      step();
      redirect = 1'b0;
      run(7);
      chk("lit_req61", {31'b0, tr_req[61]}, 32'd0);
      chk("lit_iaddr62", tr_iaddr[62], 32'h400);
      chk("lit_oaddr65", tr_oaddr[65], 32'h400);

      // asynchronous reset between edges, mid-stream
      #2;
      reset = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      model_clear();
      mem_due.delete();
      mem_addr.delete();
      m_pc = 32'd0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      run(8);
      chk("lit_req69", {31'b0, tr_req[69]}, 32'd1);
      chk("lit_iaddr69", tr_iaddr[69], 32'h0);
      chk("lit_vld71", {31'b0, tr_vld[71]}, 32'd0);
      chk("lit_oaddr72", tr_oaddr[72], 32'h0);
      chk("lit_oinstr72", tr_oinstr[72], 32'hFFFF0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end, replacing the fixed two-stage fetch (PC register plus synchronous instruction memory).
- Generates sequential PCs and issues requests to an instruction memory of configurable fixed latency.
- Buffers returned instructions with their addresses in a DEPTH-entry FIFO feeding the decoder.
- Supports decoder stall (backpressure) and branch/jump redirect (flush), discarding all stale in-flight and buffered fetches.

Parameters:
XLEN, 32, address width in bits
DEPTH, 4, FIFO entries; power of two, >= MEM_LATENCY+1
MEM_LATENCY, 2, cycles from imem_req to imem_instr valid; >= 1
RESET_PC, 0, first fetch address after reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request this cycle
imem_addr  out  XLEN  fetch address; valid when imem_req
imem_instr  in  32  instruction; valid exactly MEM_LATENCY cycles after its request; no backpressure
stall  in  1  decoder cannot accept this cycle
redirect  in  1  flush and restart fetch
redirect_addr  in  XLEN  new PC when redirect
out_valid  out  1  head entry valid
out_instr  out  32  head instruction
out_addr  out  XLEN  head address
occupancy  out  $clog2(DEPTH+1)  entries in FIFO

Behaviour:
Reset (reset low, asynchronous):
- pc=RESET_PC; FIFO empty; all in-flight valid bits cleared.
- imem_req=0, out_valid=0, occupancy=0.
- out_instr/out_addr are 0.

Request issue:
- inflight = number of set bits in a MEM_LATENCY-deep valid/address delay line.
- deq = out_valid & !stall & !redirect.
- imem_req = !redirect & (occupancy + inflight - deq < DEPTH). Combinational on registered state plus stall/redirect.
- imem_addr = pc. On an imem_req cycle, pc <= pc+4, wrapping mod 2^XLEN.

Return:
- The delay-line slot reaching the end carries valid and address.
- If valid, {imem_instr, address} is written at the FIFO tail on that edge.
- The entry is visible on out_* the following cycle. First out_valid comes MEM_LATENCY+1 cycles after the first imem_req.
- The credit rule guarantees a return never meets a full FIFO. An overflow is a design error; an assertion fires.

Dequeue:
- On a deq cycle the head pops at the edge.
- Simultaneous enqueue and dequeue leave occupancy unchanged, including at occupancy=DEPTH.
- With stall=0 and no redirect, sustained throughput is one instruction per cycle.

Redirect (priority over everything):
- In the redirect cycle: no request, no dequeue.
- At the edge: FIFO cleared, occupancy=0, all delay-line valid bits cleared, pc <= redirect_addr.
- The memory return arriving in the redirect cycle is discarded.
- Next cycle: imem_req=1 at redirect_addr.
- Back-to-back redirects: the last one wins.

Boundary and ordering:
- Pointers wrap mod DEPTH.
- No out_* output depends combinationally on imem_instr.
- FIFO order equals request order.
- Reset mid-operation discards everything; fetch restarts at RESET_PC.

Test Plan:
- Startup (DEPTH=4, MEM_LATENCY=2, memory returns instr=addr^32'hFFFF0000, stall=0): deassert reset → imem_req at cycles 0,1,2… with addr 0,4,8; out_valid from cycle 3 with out_addr 0,4,8 in consecutive cycles; occupancy holds 1.
- Stall fill: hold stall=1 from the first out_valid → occupancy rises to 4; imem_req low once occupancy+inflight=4; no entry lost; on release, addresses emerge contiguous with no gap or duplicate.
- Redirect with in-flight: at steady state, assert redirect for one cycle with redirect_addr=0x100 → next cycle occupancy=0, out_valid=0, imem_req=1 at 0x100; stale returns dropped; first out_addr after redirect is 0x100, 3 cycles later.
- Redirect with stall on a full FIFO: redirect=1, stall=1, occupancy=4 → FIFO empties; fetch resumes at redirect_addr; no dequeue counted.
- Wrap: redirect_addr=0xFFFFFFFC → out_addr sequence 0xFFFFFFFC, 0x0, 0x4.
- Asynchronous reset asserted mid-stream, between clock edges → outputs clear immediately; after release, fetch restarts at RESET_PC and no pre-reset instruction appears.
